// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub datapath: opcode encodings, flag bit
// positions and a flag-packing helper used by the ALU decoder and addsub_pipe.
package addsub_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_ADC = 2'b10;
   localparam logic [1:0] OP_SBC = 2'b11;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   function automatic logic [3:0] make_flags(input logic n, input logic z,
                                             input logic c, input logic v);
      logic [3:0] f;
      f        = '0;
      f[FLG_N] = n;
      f[FLG_Z] = z;
      f[FLG_C] = c;
      f[FLG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/addsub_seg.sv
// Combinational W-bit adder slice with carry in/out; one per carry segment.
module addsub_seg
   import addsub_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         ci,
   output logic [W-1:0] sum,
   output logic         co
);

   logic [W:0] total;

   assign total = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
   assign sum   = total[W-1:0];
   assign co    = total[W];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub unit: operand prep register followed by STAGES registered
// carry segments, NZCV flags, sideband tag and valid/ready flow control.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4,
   parameter int TAG_W  = 4
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic [3:0]       flags,
   output logic [TAG_W-1:0] tag_out
);

   localparam int SEG = WIDTH / STAGES;

   if (STAGES < 1 || STAGES > 8 || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("addsub_pipe: STAGES must be 1..8 and divide WIDTH");
   end

   logic             advance;
   logic [WIDTH-1:0] b_eff_next;
   logic             c0_next;

   logic             pv_reg;
   logic [TAG_W-1:0] ptag_reg;
   logic [WIDTH-1:0] pa_reg;
   logic [WIDTH-1:0] pb_reg;
   logic             pc_reg;

   // The whole pipe moves as one; a held output freezes every stage.
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   always_comb begin
      b_eff_next = op[0] ? ~b : b;
      case (op)
         OP_ADD:  c0_next = 1'b0;
         OP_SUB:  c0_next = 1'b1;
         default: c0_next = cin;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         pv_reg   <= 1'b0;
         ptag_reg <= '0;
         pa_reg   <= '0;
         pb_reg   <= '0;
         pc_reg   <= 1'b0;
      end else if (advance) begin
         pv_reg   <= in_valid;
         ptag_reg <= tag_in;
         pa_reg   <= a;
         pb_reg   <= b_eff_next;
         pc_reg   <= c0_next;
      end
   end

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stg
      localparam int LO   = gi * SEG;   // bits already summed on entry
      localparam int DONE = LO + SEG;

      logic                v_prev;
      logic [TAG_W-1:0]    tag_prev;
      logic [WIDTH-LO-1:0] a_prev;
      logic [WIDTH-LO-1:0] b_prev;
      logic                c_prev;
      logic [SEG-1:0]      seg_sum;
      logic                seg_co;
      logic [DONE-1:0]     sum_next;

      logic                v_reg;
      logic [TAG_W-1:0]    tag_reg;
      logic [DONE-1:0]     sum_reg;

      if (gi == 0) begin : g_src
         assign v_prev   = pv_reg;
         assign tag_prev = ptag_reg;
         assign a_prev   = pa_reg;
         assign b_prev   = pb_reg;
         assign c_prev   = pc_reg;
         assign sum_next = seg_sum;
      end else begin : g_src
         assign v_prev   = g_stg[gi-1].v_reg;
         assign tag_prev = g_stg[gi-1].tag_reg;
         assign a_prev   = g_stg[gi-1].g_up.a_reg;
         assign b_prev   = g_stg[gi-1].g_up.b_reg;
         assign c_prev   = g_stg[gi-1].g_up.c_reg;
         assign sum_next = {seg_sum, g_stg[gi-1].sum_reg};
      end

      addsub_seg #(.W(SEG)) u_seg (
         .x   (a_prev[SEG-1:0]),
         .y   (b_prev[SEG-1:0]),
         .ci  (c_prev),
         .sum (seg_sum),
         .co  (seg_co)
      );

      always_ff @(posedge clk or negedge clrn) begin
         if (!clrn) begin
            v_reg   <= 1'b0;
            tag_reg <= '0;
            sum_reg <= '0;
         end else if (advance) begin
            v_reg   <= v_prev;
            tag_reg <= tag_prev;
            sum_reg <= sum_next;
         end
      end

      if (gi < STAGES - 1) begin : g_up
         // Operand slices not yet added ride along with the partial sum.
         logic [WIDTH-DONE-1:0] a_reg;
         logic [WIDTH-DONE-1:0] b_reg;
         logic                  c_reg;

         always_ff @(posedge clk or negedge clrn) begin
            if (!clrn) begin
               a_reg <= '0;
               b_reg <= '0;
               c_reg <= 1'b0;
            end else if (advance) begin
               a_reg <= a_prev[WIDTH-LO-1:SEG];
               b_reg <= b_prev[WIDTH-LO-1:SEG];
               c_reg <= seg_co;
            end
         end
      end else begin : g_last
         logic [3:0] flags_next;
         logic [3:0] flags_reg;

         assign flags_next = make_flags(sum_next[WIDTH-1],
                                        sum_next == '0,
                                        seg_co,
                                        (a_prev[WIDTH-LO-1] == b_prev[WIDTH-LO-1]) &
                                        (sum_next[WIDTH-1] != a_prev[WIDTH-LO-1]));

         always_ff @(posedge clk or negedge clrn) begin
            if (!clrn) begin
               flags_reg <= '0;
            end else if (advance) begin
               flags_reg <= flags_next;
            end
         end
      end
   end

   assign out_valid = g_stg[STAGES-1].v_reg;
   assign s         = g_stg[STAGES-1].sum_reg;
   assign tag_out   = g_stg[STAGES-1].tag_reg;
   assign flags     = g_stg[STAGES-1].g_last.flags_reg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe: vector table on STAGES=4/1/8 instances,
// then backpressure ordering and mid-flight reset on the STAGES=4 instance.
module tb_addsub_pipe;
   import addsub_pkg::*;

   logic        clk = 1'b0;
   logic        clrn;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        cin;
   logic [3:0]  tag_in;
   logic        out_ready;
   logic        iv4, iv1, iv8;
   logic        ir4, ir1, ir8;
   logic        ov4, ov1, ov8;
   logic [31:0] s4, s1, s8;
   logic [3:0]  f4, f1, f8;
   logic [3:0]  t4, t1, t8;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   addsub_pipe #(.WIDTH(32), .STAGES(4), .TAG_W(4)) dut4 (
      .clk(clk), .clrn(clrn), .in_valid(iv4), .in_ready(ir4), .op(op), .a(a), .b(b),
      .cin(cin), .tag_in(tag_in), .out_valid(ov4), .out_ready(out_ready),
      .s(s4), .flags(f4), .tag_out(t4));

   addsub_pipe #(.WIDTH(32), .STAGES(1), .TAG_W(4)) dut1 (
      .clk(clk), .clrn(clrn), .in_valid(iv1), .in_ready(ir1), .op(op), .a(a), .b(b),
      .cin(cin), .tag_in(tag_in), .out_valid(ov1), .out_ready(out_ready),
      .s(s1), .flags(f1), .tag_out(t1));

   addsub_pipe #(.WIDTH(32), .STAGES(8), .TAG_W(4)) dut8 (
      .clk(clk), .clrn(clrn), .in_valid(iv8), .in_ready(ir8), .op(op), .a(a), .b(b),
      .cin(cin), .tag_in(tag_in), .out_valid(ov8), .out_ready(out_ready),
      .s(s8), .flags(f8), .tag_out(t8));

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [3:0]  tag;
      logic [31:0] es;
      logic [3:0]  ef;   // {N,Z,C,V}
   } vec_t;

   vec_t vt [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input int k, input int st, input logic ov,
                          input logic [31:0] sv, input logic [3:0] fv, input logic [3:0] tv,
                          input vec_t e);
      chk($sformatf("%s_valid_k%0d", nm, k), {63'd0, ov}, {63'd0, (k == st)});
      if (k == st) begin
         chk($sformatf("%s_s_tag%0d", nm, e.tag), {32'd0, sv}, {32'd0, e.es});
         chk($sformatf("%s_flags_tag%0d", nm, e.tag), {60'd0, fv}, {60'd0, e.ef});
         chk($sformatf("%s_tag_tag%0d", nm, e.tag), {60'd0, tv}, {60'd0, e.tag});
      end
   endtask

   // Independent reference: wide unsigned math for C, wide signed math for V.
   function automatic logic [35:0] ref_model(input logic [1:0] mop, input logic [31:0] ma,
                                             input logic [31:0] mb, input logic mc);
      longint ua, ub, sa, sb, cl, u, r;
      logic [31:0] rs;
      logic n, z, c, v;
      ua = longint'({32'd0, ma});
      ub = longint'({32'd0, mb});
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      cl = mc ? 64'sd1 : 64'sd0;
      u = 0;
      r = 0;
      c = 1'b0;
      case (mop)
         OP_ADD: begin u = ua + ub;            r = sa + sb;            c = (u >= 64'sh1_0000_0000); end
         OP_SUB: begin u = ua - ub;            r = sa - sb;            c = (u >= 0); end
         OP_ADC: begin u = ua + ub + cl;       r = sa + sb + cl;       c = (u >= 64'sh1_0000_0000); end
         default: begin u = ua - ub - (1 - cl); r = sa - sb - (1 - cl); c = (u >= 0); end
      endcase
      rs = u[31:0];
      n  = rs[31];
      z  = (rs == 32'd0);
      v  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      return {rs, n, z, c, v};
   endfunction

   function automatic logic [1:0] bp_op(input int i);
      logic [31:0] iv;
      iv = i;
      return iv[1:0];
   endfunction

   function automatic logic [31:0] bp_a(input int i);
      return 32'h0FFF_FFFF * (i + 1);
   endfunction

   function automatic logic [31:0] bp_b(input int i);
      return 32'hF000_0001 + 32'h1111_1111 * i;
   endfunction

   function automatic logic bp_cin(input int i);
      return ((i >> 1) & 1) == 1;
   endfunction

   initial begin
      logic [35:0] exp_r;
      logic [31:0] s_hold;
      logic [3:0]  t_hold;
      int sent, got;

      vt[0]  = '{OP_ADD, 32'd3,          32'd4,          1'b0, 4'd5,  32'd7,          4'b0000};
      vt[1]  = '{OP_SUB, 32'd3,          32'd4,          1'b0, 4'd1,  32'hFFFF_FFFF,  4'b1000};
      vt[2]  = '{OP_SUB, 32'd5,          32'd5,          1'b0, 4'd2,  32'd0,          4'b0110};
      vt[3]  = '{OP_ADD, 32'h0000_FFFF,  32'd1,          1'b0, 4'd3,  32'h0001_0000,  4'b0000};
      vt[4]  = '{OP_ADD, 32'hFFFF_FFFF,  32'd1,          1'b0, 4'd4,  32'd0,          4'b0110};
      vt[5]  = '{OP_ADD, 32'h7FFF_FFFF,  32'd1,          1'b0, 4'd6,  32'h8000_0000,  4'b1001};
      vt[6]  = '{OP_ADC, 32'hFFFF_FFFF,  32'd0,          1'b1, 4'd7,  32'd0,          4'b0110};
      vt[7]  = '{OP_SBC, 32'd5,          32'd3,          1'b1, 4'd8,  32'd2,          4'b0010};
      vt[8]  = '{OP_SBC, 32'd5,          32'd3,          1'b0, 4'd9,  32'd1,          4'b0010};
      vt[9]  = '{OP_ADD, 32'd3,          32'd4,          1'b1, 4'd10, 32'd7,          4'b0000};
      vt[10] = '{OP_SUB, 32'h8000_0000,  32'd1,          1'b0, 4'd11, 32'h7FFF_FFFF,  4'b0011};
      vt[11] = '{OP_ADC, 32'd1,          32'd1,          1'b1, 4'd12, 32'd3,          4'b0000};

      clrn = 1'b0;
      op = OP_ADD; a = '0; b = '0; cin = 1'b0; tag_in = '0;
      iv4 = 1'b0; iv1 = 1'b0; iv8 = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("reset_out_valid", {61'd0, ov4, ov1, ov8}, 64'd0);
      chk("reset_s", {32'd0, s4 | s1 | s8}, 64'd0);
      chk("reset_flags_tag", {56'd0, f4 | f1 | f8, t4 | t1 | t8}, 64'd0);
      repeat (2) @(posedge clk);
      #1 clrn = 1'b1;
      #1 chk("reset_in_ready", {61'd0, ir4, ir1, ir8}, 64'd7);

      // Vector table: each op in isolation, latency checked on all three depths.
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         op = vt[i].op; a = vt[i].a; b = vt[i].b; cin = vt[i].cin; tag_in = vt[i].tag;
         iv4 = 1'b1; iv1 = 1'b1; iv8 = 1'b1;
         #1 chk($sformatf("vec%0d_in_ready", i), {61'd0, ir4, ir1, ir8}, 64'd7);
         @(posedge clk);
         #1;
         iv4 = 1'b0; iv1 = 1'b0; iv8 = 1'b0;
         chk($sformatf("vec%0d_valid_k0", i), {61'd0, ov4, ov1, ov8}, 64'd0);
         for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            chk_out("d4", k, 4, ov4, s4, f4, t4, vt[i]);
            chk_out("d1", k, 1, ov1, s1, f1, t1, vt[i]);
            chk_out("d8", k, 8, ov8, s8, f8, t8, vt[i]);
         end
         $display("vec %0d op=%0d a=%h b=%h cin=%0d tag=%0d expect s=%h nzcv=%b",
                  i, vt[i].op, vt[i].a, vt[i].b, vt[i].cin, vt[i].tag, vt[i].es, vt[i].ef);
      end

      // Back-to-back tags 0..7 with out_ready low in cycles 6..8.
      sent = 0;
      got  = 0;
      s_hold = '0;
      t_hold = '0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         out_ready = !(c >= 6 && c <= 8);
         if (sent < 8) begin
            op = bp_op(sent); a = bp_a(sent); b = bp_b(sent); cin = bp_cin(sent);
            tag_in = sent[3:0];
            iv4 = 1'b1;
         end else begin
            iv4 = 1'b0;
         end
         #1;
         if (c < 12)
            chk($sformatf("bp_in_ready_c%0d", c), {63'd0, ir4}, {63'd0, !(c >= 6 && c <= 8)});
         if (c == 6) begin
            s_hold = s4;
            t_hold = t4;
         end
         if (c == 7 || c == 8) begin
            chk($sformatf("bp_hold_valid_c%0d", c), {63'd0, ov4}, 64'd1);
            chk($sformatf("bp_hold_s_c%0d", c), {32'd0, s4}, {32'd0, s_hold});
            chk($sformatf("bp_hold_tag_c%0d", c), {60'd0, t4}, {60'd0, t_hold});
         end
         if (ov4 && out_ready) begin
            if (got < 8) begin
               exp_r = ref_model(bp_op(got), bp_a(got), bp_b(got), bp_cin(got));
               chk($sformatf("bp_tag_n%0d", got), {60'd0, t4}, got);
               chk($sformatf("bp_s_n%0d", got), {32'd0, s4}, {32'd0, exp_r[35:4]});
               chk($sformatf("bp_flags_n%0d", got), {60'd0, f4}, {60'd0, exp_r[3:0]});
               $display("bp result %0d tag=%0d s=%h nzcv=%b", got, t4, s4, f4);
            end else begin
               chk("bp_extra_result", {60'd0, t4}, 64'hFFFF);
            end
            got++;
         end
         if (iv4 && ir4) sent++;
      end
      chk("bp_sent_count", sent, 8);
      chk("bp_result_count", got, 8);

      // Reset with results in flight: hold output, then pulse clrn.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int j = 0; j < 2; j++) begin
         op = OP_SUB; a = 32'd3; b = 32'd4 + j; cin = 1'b0; tag_in = 4'hA + j[3:0];
         iv4 = 1'b1;
         @(posedge clk);
         #1;
      end
      iv4 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pre_valid", {63'd0, ov4}, 64'd1);
      chk("rst_pre_tag", {60'd0, t4}, 64'hA);
      clrn = 1'b0;
      #1;
      chk("rst_out_valid", {63'd0, ov4}, 64'd0);
      chk("rst_s", {32'd0, s4}, 64'd0);
      chk("rst_flags", {60'd0, f4}, 64'd0);
      chk("rst_tag_out", {60'd0, t4}, 64'd0);
      @(posedge clk);
      #1;
      clrn = 1'b1;
      out_ready = 1'b1;
      #1 chk("rst_in_ready", {63'd0, ir4}, 64'd1);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("rst_no_stale_k%0d", k), {63'd0, ov4}, 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
